// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU and its command decoder.
// Opcodes, flag bit positions and the control FSM encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_GT   = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_SHL  = 4'd13;
    localparam logic [3:0] OP_ROR  = 4'd14;
    localparam logic [3:0] OP_ROL  = 4'd15;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DIV0  = 3;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_DIV_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// First step runs on the start edge; result is combinational on done.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH-1:0] src_rem;
    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_rem;
    logic [WIDTH-1:0] nxt_quo;

    // One restoring step on either fresh operands or the running state
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        rem_sh  = {src_rem, src_quo[WIDTH-1]};
        diff    = rem_sh - {1'b0, src_dvs};
        if (diff[WIDTH]) begin
            nxt_rem = rem_sh[WIDTH-1:0];
            nxt_quo = {src_quo[WIDTH-2:0], 1'b0};
        end else begin
            nxt_rem = diff[WIDTH-1:0];
            nxt_quo = {src_quo[WIDTH-2:0], 1'b1};
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign quotient  = nxt_quo;
    assign remainder = nxt_rem;

    // Iteration counter and partial remainder/quotient registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(1);
            rem_q  <= nxt_rem;
            quo_q  <= nxt_quo;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops plus an iterative divider.
// Owns the control FSM, result mux and registered outputs.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [3:0]         i_func,
    output logic               o_ready,
    output logic               o_valid,
    output logic [2*WIDTH-1:0] o_alu_out,
    output logic [3:0]         o_flags
);

    alu_state_t state_q;
    alu_state_t state_d;

    logic               accept;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] res;
    logic [3:0]         flg;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rot_r;
    logic [2*WIDTH-1:0] rot_l;
    logic [SHAMT_W-1:0] amt;

    assign accept    = i_en && o_ready;
    assign div_start = accept && (i_func == OP_DIV) && (i_b != '0);

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .start     (div_start),
        .dividend  (i_a),
        .divisor   (i_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: leave DIV_RUN on the final divider step
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (div_start) state_d = S_DIV_RUN;
            S_DIV_RUN: if (div_done || !div_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_ready = (state_q == S_IDLE);
    end

    // Single-cycle result and flag mux
    always_comb begin
        res   = '0;
        flg   = '0;
        amt   = i_b[SHAMT_W-1:0];
        sum   = {1'b0, i_a} + {1'b0, i_b};
        dif   = {1'b0, i_a} - {1'b0, i_b};
        prod  = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
        dbl   = {i_a, i_a};
        rot_r = dbl >> amt;
        rot_l = dbl << amt;
        case (i_func)
            OP_ADD: begin
                res[WIDTH-1:0]  = sum[WIDTH-1:0];
                flg[FLAG_CARRY] = sum[WIDTH];
                flg[FLAG_OVF]   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                                  (sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                res[WIDTH-1:0]  = dif[WIDTH-1:0];
                flg[FLAG_CARRY] = (i_a < i_b);
                flg[FLAG_OVF]   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                                  (dif[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_MUL: begin
                res           = prod;
                flg[FLAG_OVF] = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                res            = {i_a, {WIDTH{1'b1}}};
                flg[FLAG_DIV0] = 1'b1;
            end
            OP_AND:  res[WIDTH-1:0] = i_a & i_b;
            OP_OR:   res[WIDTH-1:0] = i_a | i_b;
            OP_NAND: res[WIDTH-1:0] = ~(i_a & i_b);
            OP_NOR:  res[WIDTH-1:0] = ~(i_a | i_b);
            OP_XOR:  res[WIDTH-1:0] = i_a ^ i_b;
            OP_XNOR: res[WIDTH-1:0] = ~(i_a ^ i_b);
            OP_EQ:   res[0] = (i_a == i_b);
            OP_GT:   res[0] = (i_a > i_b);
            OP_SHR:  res[WIDTH-1:0] = i_a >> amt;
            OP_SHL:  res[WIDTH-1:0] = i_a << amt;
            OP_ROR:  res[WIDTH-1:0] = rot_r[WIDTH-1:0];
            OP_ROL:  res[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
            default: res = '0;
        endcase
        flg[FLAG_ZERO] = (res == '0);
    end

    // Output registers: single-cycle result or finished division
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_alu_out <= '0;
            o_flags   <= '0;
        end else begin
            o_valid <= 1'b0;
            if (div_done) begin
                o_valid   <= 1'b1;
                o_alu_out <= {div_rem, div_quo};
                o_flags   <= {3'b000, ({div_rem, div_quo} == '0)};
            end else if (accept && !div_start) begin
                o_valid   <= 1'b1;
                o_alu_out <= res;
                o_flags   <= flg;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=8.
// Inputs driven and outputs sampled on the falling edge.
module tb_multicycle_alu;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic [7:0]  i_a;
    logic [7:0]  i_b;
    logic [3:0]  i_func;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_alu_out;
    logic [3:0]  o_flags;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(.WIDTH(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_func    (i_func),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_alu_out (o_alu_out),
        .o_flags   (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then check the result after it
    task automatic op(input string tag, input logic [3:0] f,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_out, input logic [3:0] exp_flg);
        i_en = 1'b1; i_func = f; i_a = a; i_b = b;
        @(negedge i_clk);
        i_en = 1'b0;
        check({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, ".out"}, {16'd0, o_alu_out}, {16'd0, exp_out});
        check({tag, ".flags"}, {28'd0, o_flags}, {28'd0, exp_flg});
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_a = '0; i_b = '0; i_func = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst.valid", {31'd0, o_valid}, 32'd0);
        check("rst.out", {16'd0, o_alu_out}, 32'd0);
        check("rst.flags", {28'd0, o_flags}, 32'd0);
        check("rst.ready", {31'd0, o_ready}, 32'd1);
        i_rst = 1'b0;

        op("add", 4'd0, 8'hF0, 8'h20, 16'h0010, 4'b0010);
        @(negedge i_clk);
        check("add.pulse", {31'd0, o_valid}, 32'd0);
        check("add.hold", {16'd0, o_alu_out}, 32'h0010);

        op("mul", 4'd2, 8'hFF, 8'hFF, 16'hFE01, 4'b0100);
        op("sub0", 4'd1, 8'h05, 8'h05, 16'h0000, 4'b0001);
        op("subov", 4'd1, 8'h80, 8'h01, 16'h007F, 4'b0100);
        op("subbr", 4'd1, 8'h03, 8'h05, 16'h00FE, 4'b0010);
        op("addov", 4'd0, 8'h7F, 8'h01, 16'h0080, 4'b0100);
        op("rol", 4'd15, 8'h81, 8'h01, 16'h0003, 4'b0000);
        op("ror", 4'd14, 8'h01, 8'h01, 16'h0080, 4'b0000);
        op("shr", 4'd12, 8'h80, 8'h07, 16'h0001, 4'b0000);
        op("shl0", 4'd13, 8'hA5, 8'h08, 16'h00A5, 4'b0000);
        op("nand", 4'd6, 8'hF0, 8'h3C, 16'h00CF, 4'b0000);
        op("xnor", 4'd9, 8'h0F, 8'hF0, 16'h0000, 4'b0001);
        op("eq", 4'd10, 8'h05, 8'h05, 16'h0001, 4'b0000);
        op("gt", 4'd11, 8'h03, 8'h09, 16'h0000, 4'b0001);

        op("div0", 4'd3, 8'h55, 8'h00, 16'h55FF, 4'b1000);
        check("div0.ready", {31'd0, o_ready}, 32'd1);

        // DIV 200/7 with noise on the inputs while busy
        i_en = 1'b1; i_func = 4'd3; i_a = 8'd200; i_b = 8'd7;
        for (int i = 1; i <= 7; i++) begin
            @(negedge i_clk);
            i_en = i[0]; i_func = 4'd0; i_a = 8'(i * 37); i_b = 8'(i);
            check("div.busy", {31'd0, o_ready}, 32'd0);
            check("div.novalid", {31'd0, o_valid}, 32'd0);
        end
        i_en = 1'b0;
        @(negedge i_clk);
        check("div.valid", {31'd0, o_valid}, 32'd1);
        check("div.out", {16'd0, o_alu_out}, 32'h041C);
        check("div.flags", {28'd0, o_flags}, 32'd0);
        check("div.ready", {31'd0, o_ready}, 32'd1);
        op("b2b", 4'd0, 8'h01, 8'h02, 16'h0003, 4'b0000);

        // Reset in the middle of a division
        i_en = 1'b1; i_func = 4'd3; i_a = 8'd200; i_b = 8'd7;
        @(negedge i_clk);
        i_en = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("abort.busy", {31'd0, o_ready}, 32'd0);
        i_rst = 1'b1;
        #1;
        check("abort.out", {16'd0, o_alu_out}, 32'd0);
        check("abort.flags", {28'd0, o_flags}, 32'd0);
        check("abort.valid", {31'd0, o_valid}, 32'd0);
        check("abort.ready", {31'd0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        op("post", 4'd5, 8'h0C, 8'h30, 16'h003C, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check("post.quiet", {31'd0, o_valid}, 32'd0);
        end
        check("post.hold", {16'd0, o_alu_out}, 32'h003C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
